// File: rtl/stage_cfg_loader_if.sv
// Config channel into stage_cfg_loader: valid/ready beats carrying a stage index and its switch word.
// Optional even-parity bit over {cfg_stage, cfg_data} when CFG_PARITY_EN is defined.
interface stage_cfg_loader_if #(
    parameter int STG_W        = 3,
    parameter int SW_PER_STAGE = 4
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [STG_W-1:0]        cfg_stage;
    logic [SW_PER_STAGE-1:0] cfg_data;
    logic                    cfg_last;
`ifdef CFG_PARITY_EN
    logic                    cfg_parity;

    modport master (output cfg_valid, cfg_stage, cfg_data, cfg_last, cfg_parity, input cfg_ready);
    modport slave  (input cfg_valid, cfg_stage, cfg_data, cfg_last, cfg_parity, output cfg_ready);
`else
    modport master (output cfg_valid, cfg_stage, cfg_data, cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, cfg_stage, cfg_data, cfg_last, output cfg_ready);
`endif
endinterface

// File: rtl/stage_cfg_loader.sv
// Purpose: shadow-loads per-stage Benes switch words and swaps them atomically into the active set at frame_sync.
// Latency: cfg_err, swap_pulse and the new switch_set appear one cycle after the triggering edge.
// Backpressure: cfg_ready is low while a complete config waits for frame_sync. Optional parity check: CFG_PARITY_EN.
module stage_cfg_loader #(
    parameter int NUM_STAGES   = 5,
    parameter int SW_PER_STAGE = 4,
    parameter int STG_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    stage_cfg_loader_if.slave       cfg,
    input  logic                    frame_sync,
    output logic [SW_PER_STAGE-1:0] switch_set [NUM_STAGES],
    output logic                    cfg_active,
    output logic                    swap_pulse,
    output logic                    cfg_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SW_PER_STAGE-1:0] shadow_q [NUM_STAGES];
    logic [SW_PER_STAGE-1:0] active_q [NUM_STAGES];
    logic [NUM_STAGES-1:0]   mask_q, mask_d, mask_wr, stage_bit;
    logic                    accept, in_range, parity_ok, beat_wr;
    logic                    do_swap, err_d;

    assign cfg.cfg_ready = (state_q != PEND);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign in_range      = (int'(cfg.cfg_stage) < NUM_STAGES);
    assign stage_bit     = in_range ? (NUM_STAGES'(1) << cfg.cfg_stage) : '0;
    assign mask_wr       = mask_q | stage_bit;

`ifdef CFG_PARITY_EN
    assign parity_ok = ~^{cfg.cfg_stage, cfg.cfg_data, cfg.cfg_parity};
`else
    assign parity_ok = 1'b1;
`endif

    assign beat_wr = accept && in_range && parity_ok;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        err_d   = 1'b0;
        do_swap = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (!beat_wr) begin
                        // Rejected beat: nothing written; a rejected commit abandons the load.
                        err_d = 1'b1;
                        if (cfg.cfg_last) begin
                            mask_d  = '0;
                            state_d = IDLE;
                        end
                    end else if (cfg.cfg_last) begin
                        if (&mask_wr) begin
                            mask_d  = mask_wr;
                            state_d = PEND;
                        end else begin
                            err_d   = 1'b1;
                            mask_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        mask_d  = mask_wr;
                        state_d = LOAD;
                    end
                end
            end
            PEND: begin
                if (frame_sync) begin
                    do_swap = 1'b1;
                    mask_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                mask_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cfg_err    <= 1'b0;
            swap_pulse <= 1'b0;
            cfg_active <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cfg_err    <= err_d;
            swap_pulse <= do_swap;
            if (do_swap) begin
                cfg_active <= 1'b1;
            end
            if (beat_wr) begin
                shadow_q[cfg.cfg_stage] <= cfg.cfg_data;
            end
            // Whole-word swap on one edge so the stages never see a mixed permutation.
            if (do_swap) begin
                for (int i = 0; i < NUM_STAGES; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign switch_set = active_q;
endmodule

// File: tb/tb_stage_cfg_loader.sv
// Bench for stage_cfg_loader: fixed vector table, hand-written corner sequences, then random beats against a reference model.
module tb_stage_cfg_loader;
    localparam int NS = 5;
    localparam int SW = 4;
    localparam int SG = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_sync = 1'b0;
    logic [SW-1:0] switch_set [NS];
    logic          cfg_active, swap_pulse, cfg_err;

    int checks = 0;
    int errors = 0;

    stage_cfg_loader_if #(.STG_W(SG), .SW_PER_STAGE(SW)) cfg_if ();

    stage_cfg_loader #(.NUM_STAGES(NS), .SW_PER_STAGE(SW), .STG_W(SG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg_if),
        .frame_sync (frame_sync),
        .switch_set (switch_set),
        .cfg_active (cfg_active),
        .swap_pulse (swap_pulse),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

`ifdef CFG_PARITY_EN
    assign cfg_if.cfg_parity = ^{cfg_if.cfg_stage, cfg_if.cfg_data};
`endif

    // Reference model: what has been written since the last commit/abort, and whether a commit is waiting.
    logic [SW-1:0] m_shadow [NS];
    logic [SW-1:0] m_act [NS];
    bit            m_wr [NS];
    bit            m_pend, m_active, m_err, m_swap;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_shadow[i] = '0;
            m_act[i]    = '0;
            m_wr[i]     = 1'b0;
        end
        m_pend = 0; m_active = 0; m_err = 0; m_swap = 0;
    endfunction

    function automatic void model_edge();
        int  st;
        bit  all;
        st = int'(cfg_if.cfg_stage);
        m_err = 0;
        m_swap = 0;
        if (m_pend) begin
            if (frame_sync) begin
                for (int i = 0; i < NS; i++) begin
                    m_act[i] = m_shadow[i];
                    m_wr[i]  = 1'b0;
                end
                m_active = 1; m_swap = 1; m_pend = 0;
            end
        end else if (cfg_if.cfg_valid) begin
            if (st >= NS) begin
                m_err = 1;
                if (cfg_if.cfg_last) for (int i = 0; i < NS; i++) m_wr[i] = 1'b0;
            end else begin
                m_shadow[st] = cfg_if.cfg_data;
                m_wr[st] = 1'b1;
                if (cfg_if.cfg_last) begin
                    all = 1;
                    for (int i = 0; i < NS; i++) if (!m_wr[i]) all = 0;
                    if (all) m_pend = 1;
                    else begin
                        m_err = 1;
                        for (int i = 0; i < NS; i++) m_wr[i] = 1'b0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [NS*SW-1:0] pack_dut();
        logic [NS*SW-1:0] p;
        for (int i = 0; i < NS; i++) p[i*SW +: SW] = switch_set[i];
        return p;
    endfunction

    function automatic logic [NS*SW-1:0] pack_model();
        logic [NS*SW-1:0] p;
        for (int i = 0; i < NS; i++) p[i*SW +: SW] = m_act[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int st, input int d, input bit l, input bit fs);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_stage = SG'(st);
        cfg_if.cfg_data  = SW'(d);
        cfg_if.cfg_last  = l;
        frame_sync       = fs;
    endtask

    // Called at a negedge with inputs set: one clock edge, model update, output comparison.
    task automatic step();
        chk("ready_pre", 32'(cfg_if.cfg_ready), 32'(!m_pend));
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        chk("switch_set", 32'(pack_dut()), 32'(pack_model()));
        chk("cfg_active", 32'(cfg_active), 32'(m_active));
        chk("swap_pulse", 32'(swap_pulse), 32'(m_swap));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
        chk("err_swap_excl", 32'(cfg_err && swap_pulse), 32'(0));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        bit v; int st; int d; bit l; bit fs;
        bit e_rdy; bit e_err; bit e_swap; bit e_act; logic [NS*SW-1:0] e_sw;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1, 0, 4'h5, 0, 0,  1, 0, 0, 0, 20'h00000};
        tbl[1] = '{1, 1, 4'h3, 0, 0,  1, 0, 0, 0, 20'h00000};
        tbl[2] = '{1, 2, 4'hF, 0, 0,  1, 0, 0, 0, 20'h00000};
        tbl[3] = '{1, 3, 4'h8, 0, 0,  1, 0, 0, 0, 20'h00000};
        tbl[4] = '{1, 4, 4'h1, 1, 0,  0, 0, 0, 0, 20'h00000};
        tbl[5] = '{0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 20'h00000};
        tbl[6] = '{0, 0, 4'h0, 0, 0,  0, 0, 0, 0, 20'h00000};
        tbl[7] = '{0, 0, 4'h0, 0, 1,  1, 0, 1, 1, 20'h18F35};
        tbl[8] = '{0, 0, 4'h0, 0, 0,  1, 0, 0, 1, 20'h18F35};

        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        idle(5);
        chk("rst_switch_set", 32'(pack_dut()), 32'(0));
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'(1));
        chk("rst_active", 32'(cfg_active), 32'(0));

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].st, tbl[i].d, tbl[i].l, tbl[i].fs);
            step();
            chk($sformatf("tbl%0d_ready", i), 32'(cfg_if.cfg_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_swap", i), 32'(swap_pulse), 32'(tbl[i].e_swap));
            chk($sformatf("tbl%0d_active", i), 32'(cfg_active), 32'(tbl[i].e_act));
            chk($sformatf("tbl%0d_sw", i), 32'(pack_dut()), 32'(tbl[i].e_sw));
        end

        // Incomplete commit: error pulse, back to idle, frame_sync has no effect.
        drive(1, 0, 4'hA, 0, 0); step();
        drive(1, 1, 4'hB, 0, 0); step();
        drive(1, 2, 4'hC, 1, 0); step();
        chk("partial_err", 32'(cfg_err), 32'(1));
        chk("partial_ready", 32'(cfg_if.cfg_ready), 32'(1));
        idle(1);
        chk("partial_err_once", 32'(cfg_err), 32'(0));
        drive(0, 0, 0, 0, 1); step();
        chk("partial_noswap", 32'(swap_pulse), 32'(0));
        chk("partial_sw", 32'(pack_dut()), 32'h18F35);

        // Out-of-range stage mid-load does not break the load.
        drive(1, 0, 4'h2, 0, 0); step();
        drive(1, 1, 4'h4, 0, 0); step();
        drive(1, 6, 4'hD, 0, 0); step();
        chk("oor_err", 32'(cfg_err), 32'(1));
        drive(1, 2, 4'h6, 0, 0); step();
        chk("oor_err_once", 32'(cfg_err), 32'(0));
        drive(1, 3, 4'h7, 0, 0); step();
        drive(1, 4, 4'h9, 1, 0); step();
        chk("oor_pend", 32'(cfg_if.cfg_ready), 32'(0));
        idle(2);
        drive(0, 0, 0, 0, 1); step();
        chk("oor_swap", 32'(swap_pulse), 32'(1));
        chk("oor_sw", 32'(pack_dut()), 32'h97642);
        idle(1);

        // Commit coinciding with frame_sync: swap waits for the next one; stage 3 rewrite wins.
        drive(1, 0, 4'h1, 0, 0); step();
        drive(1, 1, 4'h2, 0, 0); step();
        drive(1, 2, 4'h3, 0, 0); step();
        drive(1, 3, 4'h1, 0, 0); step();
        drive(1, 3, 4'hE, 0, 0); step();
        drive(1, 4, 4'h4, 1, 1); step();
        chk("sim_noswap", 32'(swap_pulse), 32'(0));
        chk("sim_pend", 32'(cfg_if.cfg_ready), 32'(0));
        idle(9);
        chk("sim_sw_hold", 32'(pack_dut()), 32'h97642);
        drive(0, 0, 0, 0, 1); step();
        chk("sim_swap", 32'(swap_pulse), 32'(1));
        chk("sim_stage3", 32'(switch_set[3]), 32'hE);
        chk("sim_sw", 32'(pack_dut()), 32'h4E321);
        idle(1);

        // Reset while a commit is pending discards both shadow and active configuration.
        for (int s = 0; s < NS; s++) begin
            drive(1, s, 4'hF, s == NS - 1, 0); step();
        end
        chk("rstp_pend", 32'(cfg_if.cfg_ready), 32'(0));
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        chk("rstp_sw", 32'(pack_dut()), 32'(0));
        chk("rstp_active", 32'(cfg_active), 32'(0));
        chk("rstp_ready", 32'(cfg_if.cfg_ready), 32'(1));
        drive(0, 0, 0, 0, 1); step();
        chk("rstp_noswap", 32'(swap_pulse), 32'(0));
        chk("rstp_sw2", 32'(pack_dut()), 32'(0));

        for (int n = 0; n < 800; n++) begin
            int st;
            st = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(NS, 7));
            drive($urandom_range(0, 3) != 0, st, int'($urandom_range(0, 15)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
